// File: rtl/bcd_pkg.sv
// Shared definitions for the time-shared binary-to-BCD conversion block.
//   state_e      : arbiter/converter FSM state encoding
//   BIN_W        : binary width of one field
//   SHIFT_CYCLES : shift steps per conversion (one per binary bit)
//   BCD_SAT      : digit value used when a result does not fit in two digits
//   add3_if_ge5  : double-dabble digit correction applied before every shift
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StShift = 2'd2,
        StWrite = 2'd3
    } state_e;

    localparam int unsigned BIN_W        = 8;
    localparam int unsigned SHIFT_CYCLES = 8;
    localparam logic [3:0]  BCD_SAT      = 4'd9;

    function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/bcd_dabble_iter.sv
// Iterative double-dabble converter, one binary bit per cycle, MSB first.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load bin and clear the BCD accumulators (the caller's LOAD cycle)
//   bin      : binary value sampled while start is high
//   hundreds : hundreds digit (0..2)
//   tens     : tens digit
//   ones     : ones digit
//   last     : high during the final shift cycle
// The digit outputs present the value produced by the current cycle's shift, so
// while last is high they already carry the finished result and the caller can
// register it on the same edge as the final shift.
module bcd_dabble_iter import bcd_pkg::*; (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic [1:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             last
);

    localparam int unsigned        CNT_W    = $clog2(SHIFT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFT_CYCLES - 1);

    logic [BIN_W-1:0] sr_q;
    logic [1:0]       hun_q;
    logic [3:0]       ten_q;
    logic [3:0]       one_q;
    logic [CNT_W-1:0] cnt_q;
    logic             run_q;

    logic [3:0]       ten_adj;
    logic [3:0]       one_adj;
    logic [1:0]       hun_d;
    logic [3:0]       ten_d;
    logic [3:0]       one_d;
    logic [BIN_W-1:0] sr_d;

    // One double-dabble step: correct digits >= 5, then shift the whole chain left.
    // Hundreds never reaches 5 for an 8-bit input, so it needs no correction.
    always_comb begin
        ten_adj = add3_if_ge5(ten_q);
        one_adj = add3_if_ge5(one_q);
        hun_d   = {hun_q[0], ten_adj[3]};
        ten_d   = {ten_adj[2:0], one_adj[3]};
        one_d   = {one_adj[2:0], sr_q[BIN_W-1]};
        sr_d    = {sr_q[BIN_W-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q  <= '0;
            hun_q <= '0;
            ten_q <= '0;
            one_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            sr_q  <= bin;
            hun_q <= '0;
            ten_q <= '0;
            one_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            sr_q  <= sr_d;
            hun_q <= hun_d;
            ten_q <= ten_d;
            one_q <= one_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                run_q <= 1'b0;
            end
        end
    end

    assign hundreds = hun_d;
    assign tens     = ten_d;
    assign ones     = one_d;
    assign last     = run_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/bcd_share_ctrl.sv
// Shares one iterative binary-to-BCD converter among N_FIELDS watch fields.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : per-field request (pulse or level), latched into pending bits
//   bin_flat  : field values, field k at [8k+7:8k]
//   tens_flat : registered tens digit per field, field k at [4k+3:4k]
//   ones_flat : registered ones digit per field, field k at [4k+3:4k]
//   ovf       : per field, last converted value exceeded 99 (digits saturated 9/9)
//   done      : one-hot one-cycle pulse in the cycle a field's digits update
//   busy      : high from LOAD through WRITE
// Round-robin arbitration: the first pending field at or after rr_q wins, and
// rr_q moves past the serviced field once its digits are written.
module bcd_share_ctrl #(
    parameter int unsigned N_FIELDS = 4,
    parameter int unsigned BIN_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_FIELDS-1:0]       req,
    input  logic [BIN_W*N_FIELDS-1:0] bin_flat,
    output logic [4*N_FIELDS-1:0]     tens_flat,
    output logic [4*N_FIELDS-1:0]     ones_flat,
    output logic [N_FIELDS-1:0]       ovf,
    output logic [N_FIELDS-1:0]       done,
    output logic                      busy
);
    import bcd_pkg::*;

    localparam int unsigned IDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FIELDS - 1);

    state_e                     state_q;
    logic [N_FIELDS-1:0]        pending_q;
    logic [IDX_W-1:0]           rr_q;
    logic [IDX_W-1:0]           grant_q;
    logic [N_FIELDS-1:0][3:0]   tens_q;
    logic [N_FIELDS-1:0][3:0]   ones_q;
    logic [N_FIELDS-1:0]        ovf_q;
    logic [N_FIELDS-1:0]        done_q;
    logic                       busy_q;

    logic [N_FIELDS-1:0][BIN_W-1:0] bin_arr;
    logic [BIN_W-1:0]               sel_bin;
    logic                           gnt_found;
    logic [IDX_W-1:0]               gnt_idx;
    logic [IDX_W-1:0]               cand;
    logic [N_FIELDS-1:0]            grant_oh;
    logic [IDX_W-1:0]               rr_next;

    logic       dab_start;
    logic [1:0] dab_hun;
    logic [3:0] dab_tens;
    logic [3:0] dab_ones;
    logic       dab_last;

    assign bin_arr = bin_flat;
    assign sel_bin = bin_arr[grant_q];

    // Rotating priority search starting at the round-robin pointer.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(N_FIELDS); i++) begin
            cand = IDX_W'((int'(rr_q) + i) % int'(N_FIELDS));
            if (!gnt_found && pending_q[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_oh          = '0;
        grant_oh[grant_q] = 1'b1;
        rr_next           = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
    end

    assign dab_start = (state_q == StLoad);

    bcd_dabble_iter u_dabble (
        .clk      (clk),
        .rst      (rst),
        .start    (dab_start),
        .bin      (sel_bin),
        .hundreds (dab_hun),
        .tens     (dab_tens),
        .ones     (dab_ones),
        .last     (dab_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= '0;
            rr_q      <= '0;
            grant_q   <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            ovf_q     <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            done_q    <= '0;
            pending_q <= pending_q | req;
            unique case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        grant_q <= gnt_idx;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    state_q <= StShift;
                end
                StShift: begin
                    // Digits and done are registered on the final shift edge so
                    // they are visible throughout the WRITE cycle.
                    if (dab_last) begin
                        done_q[grant_q] <= 1'b1;
                        if (dab_hun == 2'd0) begin
                            tens_q[grant_q] <= dab_tens;
                            ones_q[grant_q] <= dab_ones;
                            ovf_q[grant_q]  <= 1'b0;
                        end else begin
                            tens_q[grant_q] <= BCD_SAT;
                            ones_q[grant_q] <= BCD_SAT;
                            ovf_q[grant_q]  <= 1'b1;
                        end
                        state_q <= StWrite;
                    end
                end
                StWrite: begin
                    // A request arriving in this cycle survives the clear.
                    pending_q <= (pending_q & ~grant_oh) | req;
                    rr_q      <= rr_next;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign tens_flat = tens_q;
    assign ones_flat = ones_q;
    assign ovf       = ovf_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_share_ctrl.sv
module tb_bcd_share_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] bin_flat;
    logic [4*N-1:0] tens_flat;
    logic [4*N-1:0] ones_flat;
    logic [N-1:0]   ovf;
    logic [N-1:0]   done;
    logic           busy;

    bcd_share_ctrl #(
        .N_FIELDS (N),
        .BIN_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bin_flat  (bin_flat),
        .tens_flat (tens_flat),
        .ones_flat (ones_flat),
        .ovf       (ovf),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Log of done pulses with the digits visible in the same cycle.
    int         ev_f[$];
    int         ev_c[$];
    logic [3:0] ev_t[$];
    logic [3:0] ev_o[$];
    logic       ev_v[$];

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < N; k++) begin
                if (done[k] === 1'b1) begin
                    ev_f.push_back(k);
                    ev_c.push_back(cyc);
                    ev_t.push_back(tens_flat[4*k +: 4]);
                    ev_o.push_back(ones_flat[4*k +: 4]);
                    ev_v.push_back(ovf[k]);
                end
            end
        end
    end

    // Reference model: digits from decimal arithmetic, service order from the rotating pointer.
    int rr_m;
    int vals[N];
    int mt[N];
    int mo[N];
    int mv[N];

    function automatic int ref_t(int v);
        return (v > 99) ? 9 : v / 10;
    endfunction
    function automatic int ref_o(int v);
        return (v > 99) ? 9 : v % 10;
    endfunction
    function automatic int ref_v(int v);
        return (v > 99) ? 1 : 0;
    endfunction

    function automatic logic [4*N-1:0] flat_t();
        logic [4*N-1:0] r;
        for (int k = 0; k < N; k++) r[4*k +: 4] = 4'(mt[k]);
        return r;
    endfunction
    function automatic logic [4*N-1:0] flat_o();
        logic [4*N-1:0] r;
        for (int k = 0; k < N; k++) r[4*k +: 4] = 4'(mo[k]);
        return r;
    endfunction
    function automatic logic [N-1:0] flat_v();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = mv[k][0];
        return r;
    endfunction

    function automatic void model_service(int k);
        mt[k] = ref_t(vals[k]);
        mo[k] = ref_o(vals[k]);
        mv[k] = ref_v(vals[k]);
        rr_m  = (k + 1) % N;
    endfunction

    function automatic void model_reset();
        rr_m = 0;
        for (int k = 0; k < N; k++) begin
            mt[k] = 0;
            mo[k] = 0;
            mv[k] = 0;
        end
    endfunction

    task automatic tick(int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic set_bin(int k, int v);
        bin_flat[8*k +: 8] = 8'(v);
        vals[k] = v;
    endtask

    task automatic pulse(logic [N-1:0] m);
        req = m;
        tick();
        req = '0;
    endtask

    task automatic clear_log();
        ev_f.delete(); ev_c.delete(); ev_t.delete(); ev_o.delete(); ev_v.delete();
    endtask

    task automatic wait_ev(int n, int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (ev_f.size() >= n) break;
            tick();
        end
        ok = (ev_f.size() >= n);
    endtask

    task automatic wait_busy(int budget, output int l);
        l = -1;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b1) begin
                l = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic drain();
        int quiet = 0;
        for (int i = 0; i < 300 && quiet < 3; i++) begin
            quiet = (busy === 1'b0) ? quiet + 1 : 0;
            tick();
        end
        n_cmp++;
        if (quiet < 3) begin
            n_bad++;
            $display("FAIL drain: busy still high after 300 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick();
        clear_log();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        bin_flat = '0;
        for (int k = 0; k < N; k++) vals[k] = 0;
        tick();
        n_cmp++; if (tens_flat !== '0) begin n_bad++; $display("FAIL reset_tens: got %h want 0", tens_flat); end
        n_cmp++; if (ones_flat !== '0) begin n_bad++; $display("FAIL reset_ones: got %h want 0", ones_flat); end
        n_cmp++; if (ovf !== '0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_cmp++; if (done !== '0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        model_reset();
        tick();
        clear_log();
    endtask

    task automatic test_single();
        int l;
        bit ok;
        set_bin(1, 59);
        clear_log();
        pulse(4'b0010);
        wait_busy(20, l);
        n_cmp++; if (l < 0) begin n_bad++; $display("FAIL single_busy: busy never rose"); end
        wait_ev(1, 30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_done: no done pulse within budget"); end
        if (ok && l >= 0) begin
            n_cmp++; if (ev_c[0] - l != 9) begin n_bad++; $display("FAIL single_latency: done %0d cycles after grant, want 10", ev_c[0] - l + 1); end
            n_cmp++; if (ev_f[0] != 1) begin n_bad++; $display("FAIL single_field: got %0d want 1", ev_f[0]); end
            n_cmp++; if (ev_t[0] !== 4'd5 || ev_o[0] !== 4'd9 || ev_v[0] !== 1'b0) begin
                n_bad++; $display("FAIL single_digits: got %0d/%0d ovf %b want 5/9 ovf 0", ev_t[0], ev_o[0], ev_v[0]);
            end
        end
        model_service(1);
        drain();
        n_cmp++; if (ev_f.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d done pulses want 1", ev_f.size()); end
        n_cmp++; if (tens_flat !== flat_t() || ones_flat !== flat_o()) begin
            n_bad++; $display("FAIL single_hold: got %h/%h want %h/%h", tens_flat, ones_flat, flat_t(), flat_o());
        end
    endtask

    task automatic test_all_fields();
        bit ok;
        int exp_q[$];
        do_reset();
        set_bin(0, 0); set_bin(1, 9); set_bin(2, 10); set_bin(3, 99);
        for (int i = 0; i < N; i++) exp_q.push_back((rr_m + i) % N);
        pulse(4'hF);
        wait_ev(4, 80, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL all_done: got %0d pulses want 4", ev_f.size()); end
        for (int i = 0; i < ev_f.size() && i < 4; i++) begin
            int k;
            k = exp_q[i];
            n_cmp++; if (ev_f[i] != k) begin n_bad++; $display("FAIL all_order[%0d]: got %0d want %0d", i, ev_f[i], k); end
            n_cmp++; if (ev_t[i] !== 4'(ref_t(vals[k])) || ev_o[i] !== 4'(ref_o(vals[k])) || ev_v[i] !== 1'(ref_v(vals[k]))) begin
                n_bad++; $display("FAIL all_digits[%0d]: got %0d/%0d ovf %b want %0d/%0d ovf %0d",
                                  i, ev_t[i], ev_o[i], ev_v[i], ref_t(vals[k]), ref_o(vals[k]), ref_v(vals[k]));
            end
            if (i > 0) begin
                n_cmp++; if (ev_c[i] - ev_c[i-1] != 11) begin n_bad++; $display("FAIL all_spacing[%0d]: got %0d want 11", i, ev_c[i] - ev_c[i-1]); end
            end
        end
        foreach (exp_q[i]) model_service(exp_q[i]);
        drain();
    endtask

    task automatic test_overflow();
        bit ok;
        int vs[3] = '{100, 255, 42};
        foreach (vs[j]) begin
            set_bin(2, vs[j]);
            clear_log();
            pulse(4'b0100);
            wait_ev(1, 30, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_done[%0d]: no done pulse", vs[j]); end
            if (ok) begin
                n_cmp++; if (ev_f[0] != 2 || ev_t[0] !== 4'(ref_t(vs[j])) || ev_o[0] !== 4'(ref_o(vs[j])) || ev_v[0] !== 1'(ref_v(vs[j]))) begin
                    n_bad++; $display("FAIL ovf_digits[%0d]: field %0d got %0d/%0d ovf %b want %0d/%0d ovf %0d",
                                      vs[j], ev_f[0], ev_t[0], ev_o[0], ev_v[0], ref_t(vs[j]), ref_o(vs[j]), ref_v(vs[j]));
                end
            end
            model_service(2);
            drain();
        end
    endtask

    task automatic test_bin_change();
        int l;
        bit ok;
        bit seen = 1'b0;
        set_bin(0, 23);
        clear_log();
        pulse(4'b0001);
        wait_busy(20, l);
        tick(3);
        bin_flat[7:0] = 8'd77;
        for (int i = 0; i < 20; i++) begin
            if (done[0] === 1'b1) begin
                seen = 1'b1;
                pulse(4'b0001);
                break;
            end
            tick();
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL change_write: never saw done[0]"); end
        wait_ev(2, 30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL change_resvc: got %0d pulses want 2", ev_f.size()); end
        if (ok) begin
            n_cmp++; if (ev_f[0] != 0 || ev_t[0] !== 4'd2 || ev_o[0] !== 4'd3) begin
                n_bad++; $display("FAIL change_first: field %0d got %0d/%0d want 0 2/3", ev_f[0], ev_t[0], ev_o[0]);
            end
            n_cmp++; if (ev_f[1] != 0 || ev_t[1] !== 4'd7 || ev_o[1] !== 4'd7) begin
                n_bad++; $display("FAIL change_second: field %0d got %0d/%0d want 0 7/7", ev_f[1], ev_t[1], ev_o[1]);
            end
        end
        vals[0] = 77;
        model_service(0);
        drain();
    endtask

    task automatic test_reset_mid();
        int l;
        bit ok;
        set_bin(3, 200);
        clear_log();
        pulse(4'b1000);
        wait_busy(20, l);
        tick(4);
        rst = 1'b1;
        #1;
        n_cmp++; if (tens_flat !== '0 || ones_flat !== '0) begin n_bad++; $display("FAIL midrst_digits: got %h/%h want 0/0", tens_flat, ones_flat); end
        n_cmp++; if (ovf !== '0 || done !== '0) begin n_bad++; $display("FAIL midrst_flags: ovf %b done %b want 0", ovf, done); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(15);
        n_cmp++; if (ev_f.size() != 0) begin n_bad++; $display("FAIL midrst_nodone: got %0d pulses want 0", ev_f.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_idle: busy %b want 0", busy); end
        pulse(4'b1000);
        wait_ev(1, 30, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL midrst_after: no done pulse"); end
        if (ok) begin
            n_cmp++; if (ev_f[0] != 3 || ev_t[0] !== 4'd9 || ev_o[0] !== 4'd9 || ev_v[0] !== 1'b1) begin
                n_bad++; $display("FAIL midrst_result: field %0d got %0d/%0d ovf %b want 3 9/9 ovf 1", ev_f[0], ev_t[0], ev_o[0], ev_v[0]);
            end
        end
        model_service(3);
        drain();
    endtask

    task automatic test_starvation();
        bit ok;
        int p;
        int e1;
        clear_log();
        p = cyc;
        e1 = rr_m;
        req = 4'b1001;
        tick();
        req = 4'b0001;
        wait_ev(3, 60, ok);
        req = '0;
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL starve_done: got %0d pulses want 3", ev_f.size()); end
        if (ok) begin
            n_cmp++; if (ev_f[0] != e1 || ev_f[1] != 3 || ev_f[2] != 0) begin
                n_bad++; $display("FAIL starve_order: got %0d,%0d,%0d want %0d,3,0", ev_f[0], ev_f[1], ev_f[2], e1);
            end
            n_cmp++; if (ev_c[1] - p > 22) begin n_bad++; $display("FAIL starve_wait: field 3 after %0d cycles want <=22", ev_c[1] - p); end
            n_cmp++; if (ev_c[1] - ev_c[0] != 11) begin n_bad++; $display("FAIL starve_period: got %0d want 11", ev_c[1] - ev_c[0]); end
        end
        drain();
        for (int i = 3; i < ev_f.size(); i++) begin
            n_cmp++; if (ev_f[i] != 0) begin n_bad++; $display("FAIL starve_tail[%0d]: got %0d want 0", i, ev_f[i]); end
        end
        model_service(3);
        model_service(0);
    endtask

    task automatic test_random();
        bit ok;
        int bnd[4] = '{0, 99, 100, 255};
        for (int r = 0; r < 8; r++) begin
            logic [N-1:0] m;
            int exp_q[$];
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) set_bin(k, bnd[$urandom_range(0, 3)]);
                else set_bin(k, int'($urandom_range(0, 255)));
            end
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) if (m[(rr_m + i) % N]) exp_q.push_back((rr_m + i) % N);
            clear_log();
            pulse(m);
            wait_ev(exp_q.size(), 11 * N + 20, ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_done: got %0d pulses want %0d", r, ev_f.size(), exp_q.size()); end
            for (int i = 0; i < ev_f.size() && i < exp_q.size(); i++) begin
                int k;
                k = exp_q[i];
                n_cmp++; if (ev_f[i] != k || ev_t[i] !== 4'(ref_t(vals[k])) || ev_o[i] !== 4'(ref_o(vals[k])) || ev_v[i] !== 1'(ref_v(vals[k]))) begin
                    n_bad++; $display("FAIL rand%0d_ev%0d: field %0d %0d/%0d ovf %b want field %0d %0d/%0d ovf %0d",
                                      r, i, ev_f[i], ev_t[i], ev_o[i], ev_v[i], k, ref_t(vals[k]), ref_o(vals[k]), ref_v(vals[k]));
                end
                if (i > 0) begin
                    n_cmp++; if (ev_c[i] - ev_c[i-1] != 11) begin n_bad++; $display("FAIL rand%0d_spacing%0d: got %0d want 11", r, i, ev_c[i] - ev_c[i-1]); end
                end
            end
            foreach (exp_q[i]) model_service(exp_q[i]);
            drain();
            n_cmp++; if (tens_flat !== flat_t() || ones_flat !== flat_o() || ovf !== flat_v()) begin
                n_bad++; $display("FAIL rand%0d_hold: got %h/%h/%b want %h/%h/%b", r, tens_flat, ones_flat, ovf, flat_t(), flat_o(), flat_v());
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = '0;
        bin_flat = '0;
        model_reset();
        test_reset();
        test_single();
        test_all_fields();
        test_overflow();
        test_bin_change();
        test_reset_mid();
        test_starvation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_share_ctrl.md
Name: bcd_share_ctrl

Overview:
- Time-shares one iterative binary-to-BCD converter among N_FIELDS watch fields (e.g. hours, minutes, seconds, alarm).
- Each field raises a request. The block arbitrates round-robin, converts the field's 8-bit value serially (double-dabble, one bit per cycle) and latches tens/ones into per-field digit registers.
- Sits between the timekeeping counters and the 7-segment scan/decoder.

Parameters:
- N_FIELDS, 4, number of requesting fields (2..8)
- BIN_W, 8, binary width per field (fixed 8; values 0..255)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  N_FIELDS  per-field conversion request; a one-cycle pulse or a held level are both accepted
- bin_flat  in  8*N_FIELDS  field values; field k occupies bits [8k+7:8k]
- tens_flat  out  4*N_FIELDS  registered tens digit per field, field k at [4k+3:4k]
- ones_flat  out  4*N_FIELDS  registered ones digit per field
- ovf  out  N_FIELDS  per-field flag: last converted value was >99
- done  out  N_FIELDS  one-hot, one-cycle pulse when field k's digits update
- busy  out  1  high while a conversion is in progress (LOAD through WRITE)

Behaviour:
- Reset (asynchronous, rst=1), all outputs 0:
  - tens_flat, ones_flat, ovf, done, busy, pending, rr pointer, converter state.
  - A reset mid-conversion aborts it; no done pulse and no digit update follow.
- Pending capture: each cycle, pending[k] <= pending[k] | req[k].
  - The serviced bit is cleared in WRITE.
  - If req[k] and the clear coincide, set wins and field k is serviced again later.
- FSM states: IDLE, LOAD, SHIFT, WRITE.
  - IDLE: if any pending bit is set, grant the first set bit at or after rr_ptr (wrapping modulo N_FIELDS), then go to LOAD. Otherwise stay in IDLE.
  - LOAD (1 cycle): snapshot bin_flat for the granted field into the shift register and clear the BCD accumulators. Later changes to bin_flat do not affect this conversion.
  - SHIFT (8 cycles): on each cycle, first add 3 to any BCD nibble >=5, then shift left one bit, MSB first. Accumulators are hundreds (2 bits), tens (4 bits) and ones (4 bits).
  - WRITE (1 cycle):
    - If hundreds == 0: tens_k/ones_k <= result and ovf[k] <= 0.
    - Otherwise: tens_k <= 9, ones_k <= 9 (saturated) and ovf[k] <= 1.
    - done[k] = 1 for this cycle only, pending[k] cleared, rr_ptr <= granted+1 mod N_FIELDS. Return to IDLE.
- Latency: the grant decision is made in the IDLE cycle; done pulses 10 cycles later (1 LOAD + 8 SHIFT + 1 WRITE), and the updated digits are visible the same cycle. With every field pending, the field-to-field service period is 11 cycles.
- busy = 1 in LOAD, SHIFT and WRITE; 0 in IDLE.
- Digits of non-serviced fields hold their values; a field's digits change only in its WRITE cycle.
- Fairness: with all fields continuously requesting, service order is 0,1,2,...,N-1,0,...; no field waits more than N_FIELDS services.
- Boundaries:
  - bin=0 gives 0/0.
  - bin=99 gives 9/9 with ovf=0.
  - bin=100 gives 9/9 with ovf=1.
  - bin=255 gives 9/9 with ovf=1.

Decomposition:
- Shared package bcd_pkg holds:
  - FSM state encoding (IDLE=0, LOAD=1, SHIFT=2, WRITE=3)
  - BIN_W=8, SHIFT_CYCLES=8, BCD_SAT=4'd9
  - function add3_if_ge5 (nibble)
- Sub-module bcd_dabble_iter: start, bin[7:0] in; hundreds[1:0], tens[3:0], ones[3:0], last (final-shift strobe) out; the counter is internal.
- The top keeps the arbiter, pending bits, FSM and digit/ovf registers.

Test Plan:
- Reset, then a single req[1] pulse with bin field1=59: done[1] exactly 10 cycles after the grant cycle; tens1=5, ones1=9, ovf[1]=0; other fields stay 0.
- All fields request in the same cycle with values 0, 9, 10, 99: done pulses in order 0,1,2,3, spaced 11 cycles; digits 0/0, 0/9, 1/0, 9/9.
- Field 2 bin=100, then 255: tens2=9, ones2=9, ovf[2]=1 both times; then bin=42 gives 4/2 with ovf[2]=0.
- Change bin field0 from 23 to 77 during SHIFT of field 0: result 2/3. A req[0] pulse in the WRITE cycle gives a second service with result 7/7.
- rst asserted mid-SHIFT (cycle 4): all outputs 0 immediately, no done pulse, FSM in IDLE. A req after release converts normally.
- Starvation check: req[0] held high while req[3] pulses once: field 3 is serviced within 2 service periods (22 cycles); rr order is verified.
